l2_tag_plru_array: RTL and testbench
====================================

// Module: l2_tag_plru_array
// PURPOSE
//   N-way set-associative tag/valid/dirty store for the L2 cache. Replaces the
//   single-way tag array. Adds per-way valid/dirty state and victim selection
//   (invalid-first, then tree-PLRU or round-robin).
//   Sits between the L2 control FSM and the per-way data arrays. Lookup is
//   combinational off registered state; all updates take effect on the clk edge.
// PARAMETERS
//   s_offset  5                           byte-offset bits
//   s_index   4                           set-index bits
//   s_tag     32-s_offset-s_index         tag width
//   num_ways  4                           associativity; power of 2, >=2
//   num_sets  2**s_index                  number of sets
//   s_way     $clog2(num_ways)            way-number width
// PORTS
//   clk           in   1         clock
//   reset         in   1         synchronous, active-high; clears all state
//   index         in   s_index   set addressed by every operation
//   tag_in        in   s_tag     tag compared on lookup / written on load
//   access        in   1         commit hit: update replacement state for hit_way
//   mark_dirty    in   1         set dirty bit of hit_way
//   load          in   1         fill: write tag_in into victim_way of index
//   dirty_in      in   1         dirty value stored with a load (1 = write-miss fill)
//   hit           out  1         some valid way in index holds tag_in
//   hit_way       out  s_way     lowest such way; 0 when hit=0
//   victim_way    out  s_way     way a load would replace
//   victim_valid  out  1         valid bit of victim_way
//   victim_dirty  out  1         dirty bit of victim_way (writeback needed)
//   victim_tag    out  s_tag     stored tag of victim_way (writeback address)
// BEHAVIOUR
// - Reset: every valid, dirty and tag bit cleared; replacement state zeroed.
//   Reset has priority over access/mark_dirty/load in the same cycle.
//   Outputs after reset:
//     hit=0, hit_way=0, victim_way=0, victim_valid=0, victim_dirty=0, victim_tag=0.
// - Lookup: purely combinational, zero latency.
//   hit requires valid=1, so tag_in=0 never hits an invalid way.
// - Victim: lowest-numbered invalid way if any exist; otherwise the way chosen
//   by the replacement policy for that set. victim_* reflect that way.
// - load (next edge):
//   - tag[victim_way] <= tag_in, valid <= 1, dirty <= dirty_in.
//   - Counts as an access to victim_way for the replacement state.
//   - The controller must write back a dirty victim before asserting load.
// - access (next edge), only when hit=1: replacement state updated for hit_way.
//   Ignored when hit=0.
// - mark_dirty (next edge), only when hit=1: dirty[hit_way] <= 1.
//   Ignored when hit=0.
// - Collisions:
//   - load together with access/mark_dirty: load wins, the other two are ignored.
//   - access and mark_dirty may be asserted together; both apply.
// - Only set `index` is modified in any cycle. Other sets hold state.
// - No internal FSM stalls; every operation completes in one cycle.
// CONFIGURATION
//   L2_TAG_PLRU_EN defined: tree pseudo-LRU.
//   - num_ways-1 bits per set, heap order: node 0 is root, children of n are
//     2n+1 and 2n+2.
//   - Victim walk: bit=0 goes left, bit=1 goes right.
//   - On a touch of way w, every node on w's path is set to point away from w.
//   L2_TAG_PLRU_EN undefined: per-set round-robin.
//   - Counter of s_way bits per set; victim (when all ways are valid) = counter.
//   - Counter increments on every load to that set and wraps num_ways-1 -> 0.
//   - access does not change it.
// TESTING (num_ways=4)
// 1. Reset, sweep index 0..15 with tag_in=0
//    -> hit=0, victim_way=0, victim_valid=0, victim_dirty=0.
// 2. Index 3: loads of tags 0x10, 0x11, 0x12, 0x13 on consecutive cycles
//    -> victim_way 0,1,2,3 before each load. Then tag_in=0x12 -> hit=1, hit_way=2.
// 3. Continuing from 2, PLRU_EN: victim_way=0. Access tag 0x10 -> victim_way=2.
//    Without macro: victim_way=0 both before and after the access.
// 4. Index 3, tag_in=0x11, mark_dirty=1 -> next cycle dirty.
//    Drive that way to be victim -> victim_dirty=1, victim_tag=0x11.
//    Load tag 0x20 with dirty_in=0 -> 0x20 hits; 0x11 misses.
// 5. Assert load and access together -> load's way updated; access has no effect
//    on replacement state (check victim sequence).
// 6. Reset asserted in same cycle as load to index 5 tag 0x7
//    -> next cycle tag 0x7 misses, victim_valid=0 everywhere.

Source files
------------

// File: rtl/l2_tag_plru_array_if.sv
// Lookup/fill bus between the L2 control FSM (master) and the tag/valid/dirty array (slave).
interface l2_tag_plru_array_if #(
    parameter int s_offset = 5,
    parameter int s_index  = 4,
    parameter int num_ways = 4
);
    localparam int s_tag = 32 - s_offset - s_index;
    localparam int s_way = $clog2(num_ways);

    logic [s_index-1:0] index;
    logic [s_tag-1:0]   tag_in;
    logic               access;
    logic               mark_dirty;
    logic               load;
    logic               dirty_in;
    logic               hit;
    logic [s_way-1:0]   hit_way;
    logic [s_way-1:0]   victim_way;
    logic               victim_valid;
    logic               victim_dirty;
    logic [s_tag-1:0]   victim_tag;

    modport master (
        output index, tag_in, access, mark_dirty, load, dirty_in,
        input  hit, hit_way, victim_way, victim_valid, victim_dirty, victim_tag
    );

    modport slave (
        input  index, tag_in, access, mark_dirty, load, dirty_in,
        output hit, hit_way, victim_way, victim_valid, victim_dirty, victim_tag
    );
endinterface

// File: rtl/l2_tag_plru_array.sv
// N-way set-associative L2 tag/valid/dirty store with invalid-first victim selection.
// Define L2_TAG_PLRU_EN for tree pseudo-LRU replacement; otherwise per-set round-robin.
module l2_tag_plru_array #(
    parameter int s_offset = 5,
    parameter int s_index  = 4,
    parameter int num_ways = 4
) (
    input  logic               clk,
    input  logic               reset,
    l2_tag_plru_array_if.slave bus
);
    localparam int s_tag    = 32 - s_offset - s_index;
    localparam int num_sets = 2 ** s_index;
    localparam int s_way    = $clog2(num_ways);
`ifdef L2_TAG_PLRU_EN
    localparam int s_repl = num_ways - 1;
`else
    localparam int s_repl = s_way;
`endif

    logic [s_tag-1:0]    tag_q   [num_sets][num_ways];
    logic [num_ways-1:0] valid_q [num_sets];
    logic [num_ways-1:0] dirty_q [num_sets];
    logic [s_repl-1:0]   repl_q  [num_sets];

    logic [num_ways-1:0] set_valid, set_dirty, match;
    logic [s_repl-1:0]   set_repl, repl_d;
    logic                hit_s, repl_we;
    logic [s_way-1:0]    hit_way_s, policy_way, victim_way_s;

    always_comb begin
        // NOTE: every signal driven here gets a value before any conditional update, so no latch is inferred.
        set_valid = valid_q[bus.index];
        set_dirty = dirty_q[bus.index];
        set_repl  = repl_q[bus.index];
        match     = '0;
        for (int w = 0; w < num_ways; w++)
            match[w] = set_valid[w] && (tag_q[bus.index][w] == bus.tag_in);
        hit_s     = |match;
        hit_way_s = '0;
        for (int w = num_ways - 1; w >= 0; w--)
            if (match[w]) hit_way_s = s_way'(w);
    end

`ifdef L2_TAG_PLRU_EN
    logic [s_way-1:0] touch_way;

    always_comb begin
        int                node;
        logic [s_repl-1:0] bits_sh;
        node    = 0;
        bits_sh = '0;
        for (int l = 0; l < s_way; l++) begin
            bits_sh = set_repl >> node;
            node    = 2 * node + 1 + int'(bits_sh[0]);
        end
        policy_way = s_way'(node - (num_ways - 1));
    end

    assign touch_way = bus.load ? victim_way_s : hit_way_s;
    assign repl_we   = bus.load || (bus.access && hit_s);

    // Walk touch_way's path from the root, pointing each node at the other subtree.
    always_comb begin
        int               node;
        logic [s_way-1:0] way_sh;
        logic             go_right;
        node     = 0;
        way_sh   = '0;
        go_right = 1'b0;
        repl_d   = set_repl;
        for (int l = 0; l < s_way; l++) begin
            way_sh   = touch_way >> (s_way - 1 - l);
            go_right = way_sh[0];
            if (go_right) repl_d = repl_d & ~(s_repl'(1) << node);
            else          repl_d = repl_d | (s_repl'(1) << node);
            node = 2 * node + 1 + int'(go_right);
        end
    end
`else
    assign policy_way = set_repl;
    assign repl_d     = set_repl + s_repl'(1);
    assign repl_we    = bus.load;
`endif

    always_comb begin
        victim_way_s = policy_way;
        for (int w = num_ways - 1; w >= 0; w--)
            if (!set_valid[w]) victim_way_s = s_way'(w);
    end

    assign bus.hit          = hit_s;
    assign bus.hit_way      = hit_way_s;
    assign bus.victim_way   = victim_way_s;
    assign bus.victim_valid = set_valid[victim_way_s];
    assign bus.victim_dirty = set_dirty[victim_way_s];
    assign bus.victim_tag   = tag_q[bus.index][victim_way_s];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: tags are cleared along with valid/dirty so victim_tag reads 0 after reset; the array lives in flops.
            for (int s = 0; s < num_sets; s++) begin
                for (int w = 0; w < num_ways; w++) tag_q[s][w] <= '0;
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                repl_q[s]  <= '0;
            end
        end else begin
            // NOTE: non-blocking updates, so every read in this block sees pre-edge state.
            if (bus.load) begin
                tag_q[bus.index][victim_way_s]   <= bus.tag_in;
                valid_q[bus.index][victim_way_s] <= 1'b1;
                dirty_q[bus.index][victim_way_s] <= bus.dirty_in;
            end else if (bus.mark_dirty && hit_s) begin
                dirty_q[bus.index][hit_way_s] <= 1'b1;
            end
            if (repl_we) repl_q[bus.index] <= repl_d;
        end
    end
endmodule

// File: tb/tb_l2_tag_plru_array.sv
// Self-checking bench for l2_tag_plru_array: directed scenarios, then random traffic
// against a recency-based reference model (build with or without L2_TAG_PLRU_EN).
module tb_l2_tag_plru_array;
    localparam int NS = 16;
    localparam int NW = 4;
    localparam int TW = 23;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    l2_tag_plru_array_if #(.s_offset(5), .s_index(4), .num_ways(NW)) bus ();

    l2_tag_plru_array #(.s_offset(5), .s_index(4), .num_ways(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference state: contents per set/way plus the time of each way's last touch.
    bit            m_valid [NS][NW];
    bit            m_dirty [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];
    int            m_stamp [NS][NW];
    int            m_loads [NS];
    int            m_now = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic void m_lookup(input int s, input logic [TW-1:0] t, output bit h, output int hw);
        h  = 0;
        hw = 0;
        for (int w = NW - 1; w >= 0; w--)
            if (m_valid[s][w] && m_tag[s][w] == t) begin
                h  = 1;
                hw = w;
            end
    endfunction

    // Tree PLRU = at each split, leave the half holding the most recent touch.
    function automatic int m_policy(input int s);
`ifdef L2_TAG_PLRU_EN
        int lo, size, half, ml, mr;
        lo   = 0;
        size = NW;
        while (size > 1) begin
            half = size / 2;
            ml   = 0;
            mr   = 0;
            for (int w = lo; w < lo + half; w++)        if (m_stamp[s][w] > ml) ml = m_stamp[s][w];
            for (int w = lo + half; w < lo + size; w++) if (m_stamp[s][w] > mr) mr = m_stamp[s][w];
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
`else
        return m_loads[s] % NW;
`endif
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return w;
        return m_policy(s);
    endfunction

    function automatic void m_touch(input int s, input int w);
        m_now++;
        m_stamp[s][w] = m_now;
    endfunction

    task automatic model_step();
        int s = int'(bus.index);
        bit h;
        int hw, vw;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                m_loads[i] = 0;
                for (int w = 0; w < NW; w++) begin
                    m_valid[i][w] = 0;
                    m_dirty[i][w] = 0;
                    m_tag[i][w]   = '0;
                    m_stamp[i][w] = 0;
                end
            end
        end else begin
            m_lookup(s, bus.tag_in, h, hw);
            vw = m_victim(s);
            if (bus.load) begin
                m_tag[s][vw]   = bus.tag_in;
                m_valid[s][vw] = 1;
                m_dirty[s][vw] = bus.dirty_in;
                m_touch(s, vw);
                m_loads[s]++;
            end else if (h) begin
                if (bus.mark_dirty) m_dirty[s][hw] = 1;
                if (bus.access) m_touch(s, hw);
            end
        end
    endtask

    task automatic check_outputs(input string name);
        int s = int'(bus.index);
        bit h;
        int hw, vw;
        m_lookup(s, bus.tag_in, h, hw);
        vw = m_victim(s);
        check({name, ".hit"},          32'(bus.hit),          32'(h));
        check({name, ".hit_way"},      32'(bus.hit_way),      32'(hw));
        check({name, ".victim_way"},   32'(bus.victim_way),   32'(vw));
        check({name, ".victim_valid"}, 32'(bus.victim_valid), 32'(m_valid[s][vw]));
        check({name, ".victim_dirty"}, 32'(bus.victim_dirty), 32'(m_dirty[s][vw]));
        check({name, ".victim_tag"},   32'(bus.victim_tag),   32'(m_tag[s][vw]));
    endtask

    task automatic drive(input int idx, input int tg, input bit acc, input bit md, input bit ld, input bit di);
        bus.index      = 4'(idx);
        bus.tag_in     = TW'(tg);
        bus.access     = acc;
        bus.mark_dirty = md;
        bus.load       = ld;
        bus.dirty_in   = di;
    endtask

    task automatic look(input string name);
        @(negedge clk);
        check_outputs(name);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        clk_edge();
        look("rst");
        check("rst.victim_tag", 32'(bus.victim_tag), 32'h0);
        clk_edge();
        reset = 1'b0;

        // Empty array: no hits, victim is way 0 everywhere.
        for (int i = 0; i < NS; i++) begin
            drive(i, 0, 0, 0, 0, 0);
            look("t1");
            check("t1.hit", 32'(bus.hit), 32'h0);
            check("t1.victim_way", 32'(bus.victim_way), 32'h0);
            check("t1.victim_valid", 32'(bus.victim_valid), 32'h0);
            check("t1.victim_dirty", 32'(bus.victim_dirty), 32'h0);
            clk_edge();
        end

        // Fill set 3, invalid ways chosen lowest first.
        for (int i = 0; i < NW; i++) begin
            drive(3, 'h10 + i, 0, 0, 1, 0);
            look("t2.fill");
            check("t2.victim_way", 32'(bus.victim_way), 32'(i));
            clk_edge();
        end
        drive(3, 'h12, 0, 0, 0, 0);
        look("t2.lookup");
        check("t2.hit", 32'(bus.hit), 32'h1);
        check("t2.hit_way", 32'(bus.hit_way), 32'h2);
        clk_edge();

        drive(3, 'h10, 1, 0, 0, 0);
        look("t3.pre");
        check("t3.victim_pre", 32'(bus.victim_way), 32'h0);
        clk_edge();
        drive(3, 'h10, 0, 0, 0, 0);
        look("t3.post");
`ifdef L2_TAG_PLRU_EN
        check("t3.victim_post", 32'(bus.victim_way), 32'h2);
`else
        check("t3.victim_post", 32'(bus.victim_way), 32'h0);
`endif
        clk_edge();

        // Dirty way 1, steer the policy onto it, then replace it.
        drive(3, 'h11, 0, 1, 0, 0);
        look("t4.mark");
        clk_edge();
`ifdef L2_TAG_PLRU_EN
        drive(3, 'h12, 1, 0, 0, 0);
`else
        drive(3, 'h14, 0, 0, 1, 0);
`endif
        look("t4.steer");
        clk_edge();
        drive(3, 'h20, 0, 0, 1, 0);
        look("t4.evict");
        check("t4.victim_way", 32'(bus.victim_way), 32'h1);
        check("t4.victim_dirty", 32'(bus.victim_dirty), 32'h1);
        check("t4.victim_tag", 32'(bus.victim_tag), 32'h11);
        clk_edge();
        drive(3, 'h20, 0, 0, 0, 0);
        look("t4.newtag");
        check("t4.new_hit", 32'(bus.hit), 32'h1);
        check("t4.new_way", 32'(bus.hit_way), 32'h1);
        clk_edge();
        drive(3, 'h11, 0, 0, 0, 0);
        look("t4.oldtag");
        check("t4.old_hit", 32'(bus.hit), 32'h0);
        clk_edge();

        // Load together with access/mark_dirty on a hitting tag: only the load counts.
        for (int i = 0; i < NW; i++) begin
            drive(7, 'h30 + i, 0, 0, 1, 0);
            look("t5.fill");
            clk_edge();
        end
        drive(7, 'h33, 1, 1, 1, 0);
        look("t5.collide");
        check("t5.victim_way", 32'(bus.victim_way), 32'h0);
        clk_edge();
        drive(7, 'h50, 0, 0, 1, 0);
        look("t5.next");
        check("t5.hit_dup", 32'(bus.hit), 32'h0);
`ifdef L2_TAG_PLRU_EN
        check("t5.victim_next", 32'(bus.victim_way), 32'h2);
`else
        check("t5.victim_next", 32'(bus.victim_way), 32'h1);
`endif
        clk_edge();
        drive(7, 'h33, 0, 0, 0, 0);
        look("t5.after");
        check("t5.dup_way", 32'(bus.hit_way), 32'h0);
`ifdef L2_TAG_PLRU_EN
        check("t5.victim_after", 32'(bus.victim_way), 32'h1);
`else
        check("t5.victim_after", 32'(bus.victim_way), 32'h2);
`endif
        check("t5.victim_clean", 32'(bus.victim_dirty), 32'h0);
        clk_edge();

        // Reset beats a simultaneous load.
        drive(5, 'h7, 0, 0, 1, 0);
        reset = 1'b1;
        look("t6.rst_load");
        clk_edge();
        reset = 1'b0;
        drive(5, 'h7, 0, 0, 0, 0);
        look("t6.miss");
        check("t6.hit", 32'(bus.hit), 32'h0);
        clk_edge();
        for (int i = 0; i < NS; i++) begin
            drive(i, 'h7, 0, 0, 0, 0);
            look("t6.sweep");
            check("t6.victim_valid", 32'(bus.victim_valid), 32'h0);
            clk_edge();
        end

        // Random traffic over a few sets and a small tag pool so hits and evictions are frequent.
        for (int n = 0; n < 800; n++) begin
            drive($urandom_range(0, 3), $urandom_range(0, 6),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
            reset = ($urandom_range(0, 99) == 0);
            look("rnd");
            clk_edge();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
